string_assembler: RTL
=====================

STRING_ASSEMBLER -- requirements
Module: string_assembler

Interface
REQ-001 Parameter SHALL be: NULL_CHAR, 8'h00, byte value that terminates a string.
REQ-002 Ports SHALL be: clk, input, 1, sole clock; all state changes on rising edge.
REQ-003 Ports SHALL be: rst_n, input, 1, synchronous active-low reset sampled on rising edge of clk.
REQ-004 Ports SHALL be: in_char, input, 8, incoming character byte.
REQ-005 Ports SHALL be: in_valid, input, 1, in_char valid this cycle.
REQ-006 Ports SHALL be: in_ready, output, 1, block accepts in_char this cycle.
REQ-007 Ports SHALL be: flush, input, 1, abandon the current or held string.
REQ-008 Ports SHALL be: out_string, output, 64, packed string, char k at bits [8k+7:8k], first char at [7:0].
REQ-009 Ports SHALL be: out_valid, output, 1, out_string complete and stable.
REQ-010 Ports SHALL be: out_ready, input, 1, downstream length stage consumes out_string.

Function
REQ-011 The block SHALL have two states: FILL and HOLD.
REQ-012 In FILL, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-013 In HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-014 A byte SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-015 An accepted non-null byte SHALL be written to slot idx, and idx SHALL increment (3-bit write index, range 0..7).
REQ-016 An accepted NULL_CHAR SHALL not be stored, all slots >= idx SHALL read NULL_CHAR, and the state SHALL go to HOLD.
REQ-017 An accepted non-null byte at idx=7 SHALL fill slot 7 and move the state to HOLD with no terminator stored (length 8).
REQ-018 out_string SHALL be valid the cycle after the terminating or eighth byte is accepted (latency 1).
REQ-019 In HOLD, out_string SHALL stay stable until out_valid & out_ready.
REQ-020 On out_valid & out_ready, all slots SHALL clear to NULL_CHAR, idx SHALL clear to 0, and the state SHALL go to FILL.
REQ-021 Because in_ready is 0 in HOLD, there SHALL be no same-cycle pass-through from input to output.
REQ-022 A NULL_CHAR accepted at idx=0 SHALL produce an all-NULL out_string (length 0).
REQ-023 flush=1 SHALL clear all slots and idx and force FILL on the next edge, in any state.
REQ-024 When flush and in_valid are both 1, flush SHALL win and the byte SHALL be dropped.
REQ-025 When flush and out_ready are both 1 in HOLD, the string SHALL be discarded and the bench SHALL count no transfer.
REQ-026 When NULL_CHAR is not 8'h00, padding SHALL use NULL_CHAR, and the downstream length stage is only correct for 8'h00.

Reset
REQ-027 While rst_n=0 at a rising edge, the state SHALL be FILL, idx 0, and out_string 64'h0 (all slots NULL_CHAR).
REQ-028 While rst_n=0 at a rising edge, out_valid SHALL be 0 and in_ready SHALL be 1 after the edge.
REQ-029 Reset in mid-fill or in HOLD SHALL discard the partial or held string with no output transfer.
REQ-030 rst_n SHALL take priority over flush and over both handshakes.

Configuration
REQ-031 With STRING_ASSEMBLER_COUNT_EN defined, the block SHALL add output out_count[3:0] equal to the number of non-null chars held (0..8).
REQ-032 out_count SHALL be valid with out_valid and SHALL reset to 0.
REQ-033 Without STRING_ASSEMBLER_COUNT_EN, the port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-034 Shared package string_pkg SHALL hold CHAR_W=8, MAX_CHARS=8, STRING_W=64, and the FILL/HOLD state encoding.
REQ-035 string_pkg SHALL be the same package the downstream length stage uses.
REQ-036 One sub-module, char_index_counter, SHALL hold the 3-bit idx with clear, increment, and a last-slot flag.
REQ-037 The slot registers and FSM SHALL live in string_assembler.

Verification
REQ-038 The bench SHALL send "ABC",00 with out_ready=1 -> out_string=64'h0000_0000_0043_4241, out_valid one cycle after the 00, count 3.
REQ-039 The bench SHALL send 8 bytes 31..38 with no null -> out_string=64'h3837_3635_3433_3231, count 8, in_ready low in HOLD.
REQ-040 The bench SHALL send a lone 00 -> out_string=64'h0, count 0.
REQ-041 The bench SHALL send "HI",00 with out_ready=0 for 5 cycles and present the next byte -> string held, the byte not accepted, transfer on the 6th cycle, FILL after.
REQ-042 The bench SHALL send "XY" then flush together with in_valid='Z', then "Q",00 -> out_string=64'h51, 'Z' dropped.
REQ-043 The bench SHALL pulse rst_n low in HOLD -> out_valid=0 and in_ready=1 next cycle, no transfer counted.

Source files
------------

// File: rtl/string_pkg.sv
// Shared string definitions for the string assembler and the downstream
// length stage: character/string widths, slot count and the assembler
// FSM state encoding.
package string_pkg;

  localparam int CHAR_W    = 8;
  localparam int MAX_CHARS = 8;
  localparam int STRING_W  = CHAR_W * MAX_CHARS;   // 64
  localparam int IDX_W     = $clog2(MAX_CHARS);    // 3
  localparam int COUNT_W   = $clog2(MAX_CHARS + 1); // 4, holds 0..8

  // FILL: collecting bytes. HOLD: completed string presented downstream.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } asm_state_t;

  // Index of the last slot; a non-null byte written here completes a
  // string of full length with no terminator stored.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_CHARS - 1);

endpackage : string_pkg

// File: rtl/string_assembler_char_index_counter.sv
// char_index_counter: 3-bit write index for the string assembler slots.
// Clear has priority over increment; o_last flags the final slot.
module char_index_counter
  import string_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last
);

  logic [IDX_W-1:0] r_idx;

  // Index register: reset/clear to slot 0, otherwise advance on each stored byte.
  // Incrementing from the last slot wraps to 0; the assembler is in HOLD then
  // and always clears the index before filling again.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
    end else if (i_inc) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  assign o_idx  = r_idx;
  assign o_last = (r_idx == LAST_IDX);

endmodule : char_index_counter

// File: rtl/string_assembler.sv
// string_assembler: collects bytes into an 8-slot string, terminated by
// NULL_CHAR or by the eighth byte, and presents it as one 64-bit word.
// Optional feature macro: STRING_ASSEMBLER_COUNT_EN adds out_count, the
// number of non-null characters held.
//
// Handshakes: a byte moves on a rising edge where in_valid & in_ready;
// a string moves on a rising edge where out_valid & out_ready. in_ready
// is high only in FILL and out_valid only in HOLD, so neither depends
// combinationally on the other side. flush and rst_n override both.
module string_assembler
  import string_pkg::*;
#(
  parameter logic [7:0] NULL_CHAR = 8'h00
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_char,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [63:0] out_string,
  output logic        out_valid,
  input  logic        out_ready
`ifdef STRING_ASSEMBLER_COUNT_EN
  ,
  output logic [3:0]  out_count
`endif
);

  asm_state_t             r_state;
  asm_state_t             w_next_state;
  logic [CHAR_W-1:0]      r_slots [MAX_CHARS];
  logic [IDX_W-1:0]       w_idx;
  logic                   w_last;
  logic                   w_in_ready;
  logic                   w_out_valid;
  logic                   w_accept;
  logic                   w_is_null;
  logic                   w_store;
  logic                   w_terminate;
  logic                   w_xfer;
  logic                   w_clear;
  logic [STRING_W-1:0]    w_string;

  // Qualified events; flush suppresses both the byte accept and the transfer.
  assign w_accept    = in_valid & w_in_ready & ~flush;
  assign w_is_null   = (in_char == NULL_CHAR);
  assign w_store     = w_accept & ~w_is_null;
  assign w_terminate = w_accept & (w_is_null | w_last);
  assign w_xfer      = w_out_valid & out_ready & ~flush;
  assign w_clear     = flush | w_xfer;

  char_index_counter u_idx (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_inc   (w_store),
    .o_idx   (w_idx),
    .o_last  (w_last)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state: terminator or eighth byte enters HOLD, transfer or flush returns to FILL.
  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = ST_FILL;
    end else begin
      case (r_state)
        ST_FILL: if (w_terminate) w_next_state = ST_HOLD;
        ST_HOLD: if (out_ready)   w_next_state = ST_FILL;
        default:                  w_next_state = ST_FILL;
      endcase
    end
  end

  // FSM outputs: purely state-decoded, so no same-cycle input-to-output path.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_FILL: w_in_ready  = 1'b1;
      ST_HOLD: w_out_valid = 1'b1;
      default: w_in_ready  = 1'b1;
    endcase
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;

  // Slot registers: all slots return to NULL_CHAR on reset/flush/transfer, so
  // slots at or beyond the index already read as padding when a terminator arrives.
  always_ff @(posedge clk) begin
    if (!rst_n || w_clear) begin
      for (int k = 0; k < MAX_CHARS; k++) begin
        r_slots[k] <= NULL_CHAR;
      end
    end else if (w_store) begin
      r_slots[w_idx] <= in_char;
    end
  end

  // Pack slots little-end first: slot 0 lands in bits [7:0].
  always_comb begin
    w_string = '0;
    for (int k = 0; k < MAX_CHARS; k++) begin
      w_string[k*CHAR_W +: CHAR_W] = r_slots[k];
    end
  end

  assign out_string = w_string;

`ifdef STRING_ASSEMBLER_COUNT_EN
  logic [COUNT_W-1:0] r_count;

  // Non-null character count, tracking the slot writes one for one.
  always_ff @(posedge clk) begin
    if (!rst_n || w_clear) begin
      r_count <= '0;
    end else if (w_store) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign out_count = r_count;
`endif

endmodule : string_assembler
